// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
// Shared types for the key event decoder.
//   evt_code_e : event codes pushed into the event queue (2 bits wide).
//   state_e    : tap/hold classifier states.
//   EVT_W      : width of an event code.
// -----------------------------------------------------------------------------
package key_event_pkg;

  localparam int EVT_W = 2;

  typedef enum logic [EVT_W-1:0] {
    EVT_TAP        = 2'b00,
    EVT_HOLD_START = 2'b01,
    EVT_HOLD_END   = 2'b10
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HOLDING = 2'b10
  } state_e;

endpackage

// File: rtl/event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Small synchronous FIFO for gameplay events.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the queue)
//   push       : write push_data when not full, or when full and popping
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   empty/full : queue status, decoded from the occupancy register
// A push into a full queue is accepted only if a pop frees the head slot on
// the same edge; otherwise it is discarded and the contents are untouched.
// -----------------------------------------------------------------------------
module event_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  // One extra bit so that DEPTH entries is distinguishable from zero.
  logic [PTR_W:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W+1)'(DEPTH));

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Zero while empty so the consumer never sees a stale entry.
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // through pop_data, which is masked while the occupancy count says empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Turns the debounced click level of one lane button into discrete events.
//   clk, rst_n : clock, asynchronous active-low reset
//   click_in   : debounced button level, 1 = pressed
//   evt_valid  : event queue non-empty, head event on evt_code
//   evt_ready  : consumer accepts the head event when evt_valid is high
//   evt_code   : head event (TAP / HOLD_START / HOLD_END), 00 while empty
//   holding    : high while the classifier is in the HOLDING state
//   overflow   : one-cycle pulse when an event was dropped on a full queue
// A press shorter than HOLD_LIMIT samples yields TAP on release; a longer one
// yields HOLD_START on its HOLD_LIMIT-th sample and HOLD_END on release.
// -----------------------------------------------------------------------------
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int HOLD_LIMIT = 16,
  parameter int CNT_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             click_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_code,
  output logic             holding,
  output logic             overflow
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_holding;
  logic             r_overflow;

  logic             w_push;
  evt_code_e        w_push_code;
  logic [EVT_W-1:0] w_push_data;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_at_limit;

  // cnt already holds the samples seen so far, so the HOLD_LIMIT-th high
  // sample arrives while cnt == HOLD_LIMIT-1.
  assign w_at_limit = (r_cnt == CNT_W'(HOLD_LIMIT - 1));

  // Event generation is decoded from the current state and sample so the
  // push lands on the same edge as the state transition.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_push      = 1'b0;
    w_push_code = EVT_TAP;
    case (r_state)
      ST_PRESSED: begin
        if (!click_in) begin
          w_push      = 1'b1;
          w_push_code = EVT_TAP;
        end else if (w_at_limit) begin
          w_push      = 1'b1;
          w_push_code = EVT_HOLD_START;
        end
      end
      ST_HOLDING: begin
        if (!click_in) begin
          w_push      = 1'b1;
          w_push_code = EVT_HOLD_END;
        end
      end
      default: ;
    endcase
  end

  assign w_push_data = w_push_code;
  assign w_pop       = ~w_empty & evt_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_holding  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Dropped only when full and nothing leaves on this same edge.
      r_overflow <= w_push & w_full & ~w_pop;
      case (r_state)
        ST_IDLE: begin
          if (click_in) begin
            r_state <= ST_PRESSED;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!click_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_at_limit) begin
            r_state   <= ST_HOLDING;
            r_holding <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLDING: begin
          // Counter stays frozen while the hold continues.
          if (!click_in) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_holding <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_holding <= 1'b0;
        end
      endcase
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (evt_code),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign evt_valid = ~w_empty;
  assign holding   = r_holding;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
// Self-checking bench for key_event_decoder (HOLD_LIMIT=16, FIFO_DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam logic [1:0] TAP = 2'b00;
  localparam logic [1:0] HS  = 2'b01;
  localparam logic [1:0] HE  = 2'b10;

  logic       clk;
  logic       rst_n;
  logic       click_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       holding;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_decoder #(
    .HOLD_LIMIT (16),
    .CNT_W      (5),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .click_in  (click_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .holding   (holding),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       click;
    logic       ready;
    logic       valid;
    logic [1:0] code;
    logic       hold;
    logic       ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] c,
                            input logic h, input logic o);
    check({tag, ".valid"},    32'(evt_valid), 32'(v));
    check({tag, ".code"},     32'(evt_code),  32'(c));
    check({tag, ".holding"},  32'(holding),   32'(h));
    check({tag, ".overflow"}, 32'(overflow),  32'(o));
  endtask

  initial begin
    // {click, ready, valid, code, holding, overflow} after the edge
    // 5-sample tap with ready high: single TAP, visible for one cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, TAP, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    // Alternating 1,0,1,0,1,0: one TAP per press, each popped next cycle.
    vecs[8]  = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, TAP, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, TAP, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, TAP, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, TAP, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, TAP, 1'b0, 1'b0};

    rst_n     = 1'b0;
    click_in  = 1'b0;
    evt_ready = 1'b0;
    step();
    step();
    expect_out("reset", 1'b0, TAP, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      click_in  = vecs[i].click;
      evt_ready = vecs[i].ready;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code,
                 vecs[i].hold, vecs[i].ovf);
    end

    // ---- 15 samples high: still a TAP ----
    evt_ready = 1'b1;
    click_in  = 1'b1;
    for (int i = 1; i <= 15; i++) step();
    expect_out("tap15.high", 1'b0, TAP, 1'b0, 1'b0);
    click_in = 1'b0;
    step();
    expect_out("tap15.rel", 1'b1, TAP, 1'b0, 1'b0);
    step();
    expect_out("tap15.pop", 1'b0, TAP, 1'b0, 1'b0);

    // ---- 16 samples high: HOLD_START, then HOLD_END on release ----
    click_in = 1'b1;
    for (int i = 1; i <= 15; i++) step();
    expect_out("hold.s15", 1'b0, TAP, 1'b0, 1'b0);
    step();
    expect_out("hold.s16", 1'b1, HS, 1'b1, 1'b0);
    step();
    expect_out("hold.s17", 1'b0, TAP, 1'b1, 1'b0);
    step();
    expect_out("hold.s18", 1'b0, TAP, 1'b1, 1'b0);
    click_in = 1'b0;
    step();
    expect_out("hold.rel", 1'b1, HE, 1'b0, 1'b0);
    step();
    expect_out("hold.pop", 1'b0, TAP, 1'b0, 1'b0);

    // ---- 6 taps with consumer stalled: 4 queued, 2 dropped ----
    evt_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      click_in = 1'b1;
      step();
      if (t == 5) check("ovf.clear", 32'(overflow), 32'(0));
      step();
      step();
      click_in = 1'b0;
      step();
      expect_out($sformatf("stall.tap%0d", t), 1'b1, TAP, 1'b0, (t >= 4) ? 1'b1 : 1'b0);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("drain%0d", i), (i < 3) ? 1'b1 : 1'b0, TAP, 1'b0, 1'b0);
    end

    // ---- full queue, pop and push on the same edge ----
    evt_ready = 1'b0;
    click_in  = 1'b1;
    for (int i = 1; i <= 16; i++) step();
    expect_out("full.hs", 1'b1, HS, 1'b1, 1'b0);
    click_in = 1'b0; step();   // HOLD_END, 2 entries
    click_in = 1'b1; step();
    click_in = 1'b0; step();   // TAP, 3 entries
    click_in = 1'b1; step();
    click_in = 1'b0; step();   // TAP, 4 entries (full)
    click_in = 1'b1; step();
    expect_out("full.pre", 1'b1, HS, 1'b0, 1'b0);
    click_in  = 1'b0;
    evt_ready = 1'b1;
    step();                    // pop HOLD_START, push TAP
    expect_out("full.swap", 1'b1, HE, 1'b0, 1'b0);
    step();
    expect_out("full.d1", 1'b1, TAP, 1'b0, 1'b0);
    step();
    expect_out("full.d2", 1'b1, TAP, 1'b0, 1'b0);
    step();
    expect_out("full.d3", 1'b1, TAP, 1'b0, 1'b0);
    step();
    expect_out("full.d4", 1'b0, TAP, 1'b0, 1'b0);

    // ---- reset during HOLDING with 2 events queued ----
    evt_ready = 1'b0;
    click_in  = 1'b1; step();
    click_in  = 1'b0; step();  // TAP queued
    click_in  = 1'b1;
    for (int i = 1; i <= 16; i++) step();
    expect_out("rst.pre", 1'b1, TAP, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 1'b0, TAP, 1'b0, 1'b0);
    step();
    #2 rst_n = 1'b1;
    // click_in held high: the first sampled edge starts a new press.
    for (int i = 1; i <= 15; i++) step();
    expect_out("rst.s15", 1'b0, TAP, 1'b0, 1'b0);
    step();
    expect_out("rst.s16", 1'b1, HS, 1'b1, 1'b0);
    evt_ready = 1'b1;
    click_in  = 1'b0;
    step();                    // pop HOLD_START, push HOLD_END
    expect_out("rst.rel", 1'b1, HE, 1'b0, 1'b0);
    step();
    expect_out("rst.end", 1'b0, TAP, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
